// File: rtl/fpu_cvt_scheduler_pkg.sv
// Shared FPU definitions for the int-to-float conversion path: rounding-mode
// encodings, the reserved-rm predicate and the single-precision +0.0 constant.
package fpu_cvt_scheduler_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

  // 101 and 110 are reserved encodings; 111 is only legal before frm resolution.
  function automatic logic rm_is_reserved(input logic [2:0] rm);
    return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
  endfunction

endpackage

// File: rtl/fpu_cvt_to_float.sv
// Combinational 32-bit integer to IEEE single converter.
// Known behaviour relied on by its users:
//   - directed rounding (RDN/RUP) is steered by src_i[31], even for unsigned ops;
//   - a zero input yields exponent 127 rather than +0.0.
// Ports:
//   src_i      integer operand
//   unsigned_i 1 = treat src_i as unsigned
//   rm_i       rounding mode (RNE/RTZ/RDN/RUP/RMM; others behave as RTZ)
//   result_c   single-precision result
module fpu_cvt_to_float
  import fpu_cvt_scheduler_pkg::*;
(
  input  logic [31:0] src_i,
  input  logic        unsigned_i,
  input  logic [2:0]  rm_i,
  output logic [31:0] result_c
);

  logic        sign;
  logic        rnd_neg;
  logic [31:0] mag;
  logic [4:0]  msb;
  logic [30:0] norm;
  logic        lsb;
  logic        guard;
  logic        sticky;
  logic        rnd_up;
  logic [7:0]  exp_b;

  // Normalise the magnitude so the leading one sits just above bit 30.
  always_comb begin
    sign    = ~unsigned_i & src_i[31];
    rnd_neg = src_i[31];
    mag     = sign ? (~src_i + 32'd1) : src_i;
    msb     = 5'd0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (((mag >> i) & 32'd1) != 32'd0) msb = 5'(i);
    end
    norm   = 31'(mag << (5'd31 - msb));
    lsb    = norm[8];
    guard  = norm[7];
    sticky = |norm[6:0];
    exp_b  = 8'd127 + {3'b000, msb};
    case (rm_i)
      RM_RNE:  rnd_up = guard & (sticky | lsb);
      RM_RTZ:  rnd_up = 1'b0;
      RM_RDN:  rnd_up = (guard | sticky) & rnd_neg;
      RM_RUP:  rnd_up = (guard | sticky) & ~rnd_neg;
      RM_RMM:  rnd_up = guard;
      default: rnd_up = 1'b0;
    endcase
    // Mantissa carry-out ripples into the exponent field.
    result_c = {sign, exp_b, norm[30:8]} + {31'd0, rnd_up};
  end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer
// (modulo NUM_REQ); the pointer moves past the grantee when advance_i is set.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-low reset
//   req_i           request vector
//   advance_i       grant was taken this cycle
//   gnt_c           one-hot grant (combinational)
//   gnt_id_c        grant index (combinational)
//   gnt_valid_c     any request present (combinational)
module fpu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [ID_W-1:0]    gnt_id_c,
  output logic               gnt_valid_c
);

  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [NUM_REQ-1:0] req_rot;
  logic               found;
  int unsigned        gnt_idx;

  // Rotate requests so the pointer position becomes bit 0, then priority-pick.
  always_comb begin
    req_rot = NUM_REQ'({req_i, req_i} >> rr_ptr_q);
    found   = 1'b0;
    gnt_idx = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      if (!found && (((req_rot >> off) & NUM_REQ'(1)) != '0)) begin
        found   = 1'b1;
        gnt_idx = 32'(rr_ptr_q) + off;
      end
    end
    if (gnt_idx >= NUM_REQ) gnt_idx = gnt_idx - NUM_REQ;
    gnt_valid_c = found;
    gnt_id_c    = ID_W'(gnt_idx);
    gnt_c       = found ? (NUM_REQ'(1) << gnt_idx) : '0;
    rr_ptr_d    = rr_ptr_q;
    if (advance_i) begin
      rr_ptr_d = (gnt_idx == NUM_REQ - 1) ? '0 : ID_W'(gnt_idx + 32'd1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/fpu_cvt_scheduler.sv
// Shares one int-to-float converter between NUM_REQ requesters through a
// round-robin arbiter and a 2-stage valid/ready pipeline (S1 operand, S2 result).
// Resolves DYN rounding against frm, flags reserved modes and corrects the
// converter's sign-steered rounding and zero-input behaviour.
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      per-requester handshake (ready is combinational)
//   req_src_i, req_unsigned_i,
//   req_rm_i, req_tag_i            per-requester operand fields, packed by index
//   frm_i                          fcsr.frm, sampled at accept
//   flush_i                        drops every in-flight op on the next edge
//   resp_valid_o / resp_ready_i    result handshake
//   resp_data_o, resp_tag_o,
//   resp_id_o, resp_illegal_o      result payload
module fpu_cvt_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1,
  parameter int unsigned TAG_W   = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [32*NUM_REQ-1:0]    req_src_i,
  input  logic [NUM_REQ-1:0]       req_unsigned_i,
  input  logic [3*NUM_REQ-1:0]     req_rm_i,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag_i,
  input  logic [2:0]               frm_i,
  input  logic                     flush_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [31:0]              resp_data_o,
  output logic [TAG_W-1:0]         resp_tag_o,
  output logic [ID_W-1:0]          resp_id_o,
  output logic                     resp_illegal_o
);
  import fpu_cvt_scheduler_pkg::*;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;

  logic               s1_load;
  logic               s2_load;
  logic               take;
  logic               accept;

  logic [31:0]        sel_src;
  logic               sel_uns;
  logic [2:0]         sel_rm;
  logic [TAG_W-1:0]   sel_tag;
  logic [2:0]         rm_res;
  logic [2:0]         rm_eff;
  logic               sel_illegal;

  logic [31:0]        cvt_result;

  logic               s1_valid_q,   s1_valid_d;
  logic [31:0]        s1_src_q,     s1_src_d;
  logic               s1_uns_q,     s1_uns_d;
  logic [2:0]         s1_rm_q,      s1_rm_d;
  logic [TAG_W-1:0]   s1_tag_q,     s1_tag_d;
  logic [ID_W-1:0]    s1_id_q,      s1_id_d;
  logic               s1_illegal_q, s1_illegal_d;

  logic               s2_valid_q,   s2_valid_d;
  logic [31:0]        s2_data_q,    s2_data_d;
  logic [TAG_W-1:0]   s2_tag_q,     s2_tag_d;
  logic [ID_W-1:0]    s2_id_q,      s2_id_d;
  logic               s2_illegal_q, s2_illegal_d;

  fpu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (req_valid_i),
    .advance_i   (accept),
    .gnt_c       (gnt_oh),
    .gnt_id_c    (gnt_id),
    .gnt_valid_c (gnt_valid)
  );

  // Pipeline advance and accept; reset and flush both hold every requester off.
  always_comb begin
    s2_load     = s1_valid_q & (~s2_valid_q | resp_ready_i);
    s1_load     = ~s1_valid_q | s2_load;
    take        = s1_load & ~flush_i & reset_i;
    accept      = take & gnt_valid;
    req_ready_o = take ? gnt_oh : '0;
  end

  // Granted requester's fields, rm resolution and the unsigned RDN/RUP swap.
  always_comb begin
    sel_src     = 32'(req_src_i >> (32'd32 * 32'(gnt_id)));
    sel_uns     = 1'(req_unsigned_i >> gnt_id);
    sel_rm      = 3'(req_rm_i >> (32'd3 * 32'(gnt_id)));
    sel_tag     = TAG_W'(req_tag_i >> (TAG_W * 32'(gnt_id)));
    rm_res      = (sel_rm == RM_DYN) ? frm_i : sel_rm;
    sel_illegal = rm_is_reserved(rm_res);
    rm_eff      = rm_res;
    // The converter rounds a set bit 31 as if negative; invert direction for
    // unsigned operands so the value rounds as the positive number it is.
    if (sel_uns && sel_src[31]) begin
      if (rm_res == RM_RDN)      rm_eff = RM_RUP;
      else if (rm_res == RM_RUP) rm_eff = RM_RDN;
    end
  end

  fpu_cvt_to_float u_cvt (
    .src_i      (s1_src_q),
    .unsigned_i (s1_uns_q),
    .rm_i       (s1_rm_q),
    .result_c   (cvt_result)
  );

  // Stage next-state.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_src_d     = s1_src_q;
    s1_uns_d     = s1_uns_q;
    s1_rm_d      = s1_rm_q;
    s1_tag_d     = s1_tag_q;
    s1_id_d      = s1_id_q;
    s1_illegal_d = s1_illegal_q;
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_tag_d     = s2_tag_q;
    s2_id_d      = s2_id_q;
    s2_illegal_d = s2_illegal_q;

    if (flush_i)      s1_valid_d = 1'b0;
    else if (s1_load) s1_valid_d = accept;
    if (accept) begin
      s1_src_d     = sel_src;
      s1_uns_d     = sel_uns;
      s1_rm_d      = rm_eff;
      s1_tag_d     = sel_tag;
      s1_id_d      = gnt_id;
      s1_illegal_d = sel_illegal;
    end

    if (flush_i)           s2_valid_d = 1'b0;
    else if (s2_load)      s2_valid_d = 1'b1;
    else if (resp_ready_i) s2_valid_d = 1'b0;
    // Payload only moves on load, so it holds while stalled.
    if (s2_load) begin
      if (s1_illegal_q)             s2_data_d = 32'h0;
      else if (s1_src_q == 32'd0)   s2_data_d = FP32_POS_ZERO;
      else                          s2_data_d = cvt_result;
      s2_tag_d     = s1_tag_q;
      s2_id_d      = s1_id_q;
      s2_illegal_d = s1_illegal_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_valid_q   <= 1'b0;
      s1_src_q     <= '0;
      s1_uns_q     <= 1'b0;
      s1_rm_q      <= '0;
      s1_tag_q     <= '0;
      s1_id_q      <= '0;
      s1_illegal_q <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_tag_q     <= '0;
      s2_id_q      <= '0;
      s2_illegal_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_src_q     <= s1_src_d;
      s1_uns_q     <= s1_uns_d;
      s1_rm_q      <= s1_rm_d;
      s1_tag_q     <= s1_tag_d;
      s1_id_q      <= s1_id_d;
      s1_illegal_q <= s1_illegal_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_tag_q     <= s2_tag_d;
      s2_id_q      <= s2_id_d;
      s2_illegal_q <= s2_illegal_d;
    end
  end

  assign resp_valid_o   = s2_valid_q;
  assign resp_data_o    = s2_data_q;
  assign resp_tag_o     = s2_tag_q;
  assign resp_id_o      = s2_id_q;
  assign resp_illegal_o = s2_illegal_q;

endmodule

// File: tb/tb_fpu_cvt_scheduler.sv
// Bench for fpu_cvt_scheduler: a FIFO-of-ops model with an exact-arithmetic
// int-to-float reference, compared against the DUT every cycle.
module tb_fpu_cvt_scheduler;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ID_W    = 1;
  localparam int unsigned TAG_W   = 5;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req_src_i;
  logic [1:0]  req_unsigned_i;
  logic [5:0]  req_rm_i;
  logic [9:0]  req_tag_i;
  logic [2:0]  frm_i;
  logic        flush_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_tag_o;
  logic [0:0]  resp_id_o;
  logic        resp_illegal_o;

  logic [31:0] src_a     [2];
  logic        uns_a     [2];
  logic [2:0]  rm_a      [2];
  logic [4:0]  tag_a     [2];
  logic        has_lit_a [2];
  logic [31:0] lit_a     [2];
  logic        lit_ill_a [2];

  assign req_src_i      = {src_a[1], src_a[0]};
  assign req_unsigned_i = {uns_a[1], uns_a[0]};
  assign req_rm_i       = {rm_a[1], rm_a[0]};
  assign req_tag_i      = {tag_a[1], tag_a[0]};

  typedef struct {
    int          acc;
    logic [31:0] data;
    logic [4:0]  tag;
    logic        id;
    logic        ill;
    logic        has_lit;
    logic [31:0] lit;
    logic        lit_ill;
  } ent_t;

  ent_t q[$];
  int   rr;
  int   cyc;
  int   checks;
  int   failures;

  fpu_cvt_scheduler #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .TAG_W   (TAG_W)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_src_i      (req_src_i),
    .req_unsigned_i (req_unsigned_i),
    .req_rm_i       (req_rm_i),
    .req_tag_i      (req_tag_i),
    .frm_i          (frm_i),
    .flush_i        (flush_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_data_o    (resp_data_o),
    .resp_tag_o     (resp_tag_o),
    .resp_id_o      (resp_id_o),
    .resp_illegal_o (resp_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Exact conversion from the integer value: returns {illegal, ieee_bits}.
  function automatic logic [32:0] ref_cvt(input logic [31:0] src, input logic uns,
                                          input logic [2:0] rm, input logic [2:0] frm);
    logic [2:0] r;
    longint     mag, qv, rem, half;
    int         e;
    logic       sgn, up;
    r = (rm == 3'd7) ? frm : rm;
    if (r >= 3'd5) return {1'b1, 32'h0};
    if (src == 32'd0) return {1'b0, 32'h0};
    sgn = !uns && src[31];
    mag = longint'(src);
    if (sgn) mag = 64'h1_0000_0000 - mag;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      qv = mag << (23 - e); rem = 0; half = 1;
    end else begin
      qv   = mag >> (e - 23);
      rem  = mag - (qv << (e - 23));
      half = longint'(1) << (e - 24);
    end
    case (r)
      3'd0:    up = (rem > half) || ((rem == half) && ((qv % 2) == 1));
      3'd1:    up = 1'b0;
      3'd2:    up = sgn && (rem != 0);
      3'd3:    up = !sgn && (rem != 0);
      default: up = (rem >= half);
    endcase
    if (up) qv = qv + 1;
    if (qv == (longint'(1) << 24)) begin qv = qv >> 1; e++; end
    return {1'b0, sgn, 8'(e + 127), 23'(qv)};
  endfunction

  // One clock: compare at negedge+1, then advance the model across the posedge.
  task automatic do_cycle();
    int          g;
    logic        gok;
    logic [1:0]  exp_ready;
    logic        exp_rv;
    logic        was_flush;
    logic        consume;
    logic [32:0] r;
    ent_t        en;
    #1;
    gok = 1'b0; g = 0;
    for (int off = 0; off < 2; off++) begin
      int idx;
      idx = (rr + off) % 2;
      if (!gok && (((req_valid_i >> idx) & 2'b01) != 2'b00)) begin gok = 1'b1; g = idx; end
    end
    exp_rv    = (q.size() > 0) && (q[0].acc + 2 <= cyc);
    exp_ready = (!flush_i && gok && ((q.size() < 2) || resp_ready_i)) ? 2'(1 << g) : 2'b00;
    chk("req_ready", 32'(req_ready_o), 32'(exp_ready));
    chk("resp_valid", 32'(resp_valid_o), 32'(exp_rv));
    if (exp_rv) begin
      chk("resp_data", resp_data_o, q[0].data);
      chk("resp_tag", 32'(resp_tag_o), 32'(q[0].tag));
      chk("resp_id", 32'(resp_id_o), 32'(q[0].id));
      chk("resp_illegal", 32'(resp_illegal_o), 32'(q[0].ill));
      if (q[0].has_lit) begin
        chk("lit_data", resp_data_o, q[0].lit);
        chk("lit_illegal", 32'(resp_illegal_o), 32'(q[0].lit_ill));
      end
    end
    was_flush = flush_i;
    consume   = exp_rv && resp_ready_i;
    if (exp_ready != 2'b00) begin
      r          = ref_cvt(src_a[g], uns_a[g], rm_a[g], frm_i);
      en.acc     = cyc;
      en.data    = r[31:0];
      en.ill     = r[32];
      en.tag     = tag_a[g];
      en.id      = 1'(g);
      en.has_lit = has_lit_a[g];
      en.lit     = lit_a[g];
      en.lit_ill = lit_ill_a[g];
    end
    @(posedge clk_i);
    if (was_flush) q.delete();
    else begin
      if (consume) void'(q.pop_front());
      if (exp_ready != 2'b00) begin
        q.push_back(en);
        rr = (g + 1) % 2;
      end
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic rand_req(input int r);
    case ($urandom_range(0, 5))
      0:       src_a[r] = 32'h0;
      1:       src_a[r] = 32'($urandom_range(0, 255));
      2:       src_a[r] = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      3:       src_a[r] = 32'h8000_0000;
      default: src_a[r] = $urandom;
    endcase
    uns_a[r]     = 1'($urandom_range(0, 1));
    rm_a[r]      = 3'($urandom_range(0, 7));
    tag_a[r]     = 5'($urandom_range(0, 31));
    has_lit_a[r] = 1'b0;
    lit_a[r]     = 32'h0;
    lit_ill_a[r] = 1'b0;
  endtask

  // Single op on requester r with a hand-computed expected result, then drain.
  task automatic issue(input int r, input logic [31:0] s, input logic u, input logic [2:0] rm,
                       input logic [2:0] frm, input logic [31:0] lit, input logic lill);
    src_a[r]     = s;
    uns_a[r]     = u;
    rm_a[r]      = rm;
    tag_a[r]     = 5'(cyc);
    has_lit_a[r] = 1'b1;
    lit_a[r]     = lit;
    lit_ill_a[r] = lill;
    frm_i        = frm;
    flush_i      = 1'b0;
    resp_ready_i = 1'b1;
    req_valid_i  = 2'(1 << r);
    do_cycle();
    req_valid_i  = 2'b00;
    has_lit_a[r] = 1'b0;
    repeat (3) do_cycle();
  endtask

  initial begin
    logic [32:0] m;
    checks = 0; failures = 0; rr = 0; cyc = 0;
    rand_req(0); rand_req(1);
    reset_i      = 1'b0;
    req_valid_i  = 2'b11;
    frm_i        = 3'd0;
    flush_i      = 1'b0;
    resp_ready_i = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'h0);
    chk("rst_resp_data", resp_data_o, 32'h0);
    chk("rst_resp_tag", 32'(resp_tag_o), 32'h0);
    chk("rst_resp_id", 32'(resp_id_o), 32'h0);
    chk("rst_resp_illegal", 32'(resp_illegal_o), 32'h0);

    // Reference model pinned to known encodings.
    m = ref_cvt(32'h0000_0001, 1'b0, 3'd0, 3'd0); chk("model_one", m[31:0], 32'h3F80_0000);
    m = ref_cvt(32'hFFFF_FFFF, 1'b0, 3'd7, 3'd0); chk("model_neg_one", m[31:0], 32'hBF80_0000);
    m = ref_cvt(32'h7FFF_FFFF, 1'b0, 3'd0, 3'd0); chk("model_max_s", m[31:0], 32'h4F00_0000);
    m = ref_cvt(32'hFFFF_FFFF, 1'b1, 3'd0, 3'd0); chk("model_max_u", m[31:0], 32'h4F80_0000);
    m = ref_cvt(32'hFFFF_FF81, 1'b1, 3'd3, 3'd0); chk("model_u_rup", m[31:0], 32'h4F80_0000);
    m = ref_cvt(32'hFFFF_FF81, 1'b1, 3'd2, 3'd0); chk("model_u_rdn", m[31:0], 32'h4F7F_FFFF);
    m = ref_cvt(32'h0000_0000, 1'b0, 3'd1, 3'd0); chk("model_zero", m[31:0], 32'h0);
    m = ref_cvt(32'h0000_0005, 1'b0, 3'd5, 3'd0); chk("model_illegal", 32'(m[32]), 32'h1);

    @(negedge clk_i);
    reset_i     = 1'b1;
    req_valid_i = 2'b00;

    // Directed corners with literal expectations.
    issue(0, 32'h0000_0001, 1'b0, 3'd0, 3'd0, 32'h3F80_0000, 1'b0);
    issue(0, 32'hFFFF_FFFF, 1'b0, 3'd7, 3'd0, 32'hBF80_0000, 1'b0);
    issue(1, 32'h0000_0000, 1'b0, 3'd3, 3'd0, 32'h0000_0000, 1'b0);
    issue(0, 32'h7FFF_FFFF, 1'b0, 3'd0, 3'd0, 32'h4F00_0000, 1'b0);
    issue(1, 32'hFFFF_FFFF, 1'b1, 3'd0, 3'd0, 32'h4F80_0000, 1'b0);
    issue(0, 32'hFFFF_FF81, 1'b1, 3'd3, 3'd0, 32'h4F80_0000, 1'b0);
    issue(1, 32'hFFFF_FF81, 1'b1, 3'd2, 3'd0, 32'h4F7F_FFFF, 1'b0);
    issue(0, 32'h8000_0001, 1'b0, 3'd2, 3'd0, 32'hCF00_0000, 1'b0);
    issue(0, 32'h0000_0005, 1'b0, 3'd5, 3'd0, 32'h0000_0000, 1'b1);
    issue(1, 32'h0000_0005, 1'b0, 3'd7, 3'd6, 32'h0000_0000, 1'b1);
    issue(0, 32'h0000_0000, 1'b0, 3'd7, 3'd7, 32'h0000_0000, 1'b1);

    // Both requesters streaming with no backpressure.
    frm_i = 3'd0; resp_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_req(0); rand_req(1);
      tag_a[0] = 5'(2 * i); tag_a[1] = 5'(2 * i + 1);
      req_valid_i = 2'b11;
      do_cycle();
    end
    req_valid_i = 2'b00;
    repeat (3) do_cycle();

    // Two ops stalled behind backpressure, then flushed.
    resp_ready_i = 1'b0;
    rand_req(1); req_valid_i = 2'b10; do_cycle();
    rand_req(0); req_valid_i = 2'b01; do_cycle();
    req_valid_i = 2'b00;
    repeat (3) do_cycle();
    req_valid_i = 2'b11; flush_i = 1'b1;
    do_cycle();
    flush_i = 1'b0; req_valid_i = 2'b00;
    #1;
    chk("flush_clears_resp_valid", 32'(resp_valid_o), 32'h0);
    do_cycle();
    req_valid_i = 2'b11; resp_ready_i = 1'b1;
    #1;
    chk("rr_held_after_flush", 32'(req_ready_o), 32'h2);
    do_cycle();
    req_valid_i = 2'b00;
    repeat (3) do_cycle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rand_req(0); rand_req(1);
      req_valid_i  = 2'($urandom_range(0, 3));
      resp_ready_i = ($urandom_range(0, 3) != 0);
      flush_i      = ($urandom_range(0, 31) == 0);
      frm_i        = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      do_cycle();
    end
    req_valid_i = 2'b00; flush_i = 1'b0; resp_ready_i = 1'b1;
    repeat (4) do_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_cvt_scheduler.md
Name: fpu_cvt_scheduler

Overview:
- Shares one combinational `fpu_cvt_to_float` int-to-float converter between NUM_REQ requesters, e.g. integer pipe FCVT.S.W[U] issue and a microcode/replay port.
- Round-robin arbitration, rounding-mode resolution against `frm`, converter-quirk correction and a 2-stage valid/ready pipeline around the converter.
- Sits in the FPU between issue and writeback arbitration.

Parameters:
- NUM_REQ, 2, number of requesters.
- ID_W, 1, width of the requester index; must be at least clog2(NUM_REQ).
- TAG_W, 5, opaque tag carried with each op (typically rd).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-requester op valid.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high.
- req_src_i  in  32*NUM_REQ  integer operand, requester i at [32i+31:32i].
- req_unsigned_i  in  NUM_REQ  1 = FCVT.S.WU.
- req_rm_i  in  3*NUM_REQ  instruction rm field.
- req_tag_i  in  TAG_W*NUM_REQ  tag.
- frm_i  in  3  fcsr.frm.
- flush_i  in  1  kill all in-flight ops.
- resp_valid_o  out  1  result valid.
- resp_ready_i  in  1  consumer accept.
- resp_data_o  out  32  IEEE single result.
- resp_tag_o  out  TAG_W  tag of result.
- resp_id_o  out  ID_W  requester index of result.
- resp_illegal_o  out  1  resolved rm was reserved; resp_data_o = 0.

Behaviour:
- Reset (reset_i low, asynchronous): s1_valid = 0, s2_valid = 0, rr_ptr = 0. All outputs are 0, including req_ready_o = 0 and resp_valid_o = 0.
- Stage advance:
  - s2_load = s1_valid & (~s2_valid | resp_ready_i).
  - s1_load = ~s1_valid | s2_load.
- Arbitration:
  - Round-robin starting at rr_ptr; the grant goes to the first valid requester at or after rr_ptr, modulo NUM_REQ.
  - req_ready_o[g] = s1_load & ~flush_i. It is combinational and never depends on the same requester's req_valid_i except through grant selection.
  - On accept, rr_ptr <= g+1, wrapping NUM_REQ-1 -> 0. rr_ptr is unchanged when nothing is accepted.
- S1 register captures src, unsigned, rm_eff, tag, id and illegal.
- rm resolution:
  - rm_res = (rm==3'b111) ? frm_i : rm.
  - illegal = rm_res is 101, 110 or 111. frm_i is sampled at accept.
- Converter quirk 1, sign-directed rounding: the converter takes rounding direction from src[31] even for unsigned ops.
  - If unsigned & src[31], rm_eff swaps 010 (RDN) <-> 011 (RUP).
  - All other modes pass through.
- Converter quirk 2, zero input: the converter produces exponent 127 for a zero input. S2 forces +0.0 (32'h0) when s1_src == 0.
- S2 register captures the converter output (or override), tag, id and illegal. When illegal, data = 0.
- Output: resp_* are driven from S2. A result is consumed when resp_valid_o & resp_ready_i.
- Latency and throughput:
  - Accept at cycle N -> resp_valid_o at N+2 with no backpressure.
  - Sustained throughput is 1 op/cycle.
  - Under backpressure S2 holds stable, then S1 holds, then req_ready_o drops. No op is lost or duplicated.
- flush_i:
  - Next edge clears s1_valid and s2_valid; rr_ptr is held.
  - Flush has priority over accept: req_ready_o = 0 while flush_i is high.
  - A response presented during the flush cycle may still handshake; the consumer disregards it.
- resp_data_o, resp_tag_o and resp_id_o hold their value while resp_valid_o & ~resp_ready_i.
- No exception flags are produced; NX is out of scope.

Decomposition:
- Shared fpu package holds:
  - rounding-mode constants RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111;
  - the reserved-rm predicate;
  - the +0.0 constant.
- One sub-module, `fpu_rr_arbiter` (NUM_REQ-wide round-robin grant plus pointer update).
- The converter is instantiated directly.

Test Plan:
- Signed src=32'h00000001, rm=000 on req 0 -> two cycles later resp_data_o=32'h3F800000, resp_id_o=0.
- Signed src=32'hFFFFFFFF, rm=111 with frm_i=000 -> resp_data_o=32'hBF800000.
- Zero and large-value corners:
  - src=0, any legal rm -> resp_data_o=32'h00000000.
  - src=32'h7FFFFFFF, RNE -> 32'h4F000000.
  - unsigned src=32'hFFFFFFFF, RNE -> 32'h4F800000.
- Unsigned src=32'hFFFFFF81:
  - rm=011 -> 32'h4F800000 (rounded up);
  - rm=010 -> 32'h4F7FFFFF (truncated), confirming the RDN/RUP swap.
- Both requesters valid continuously with resp_ready_i=1 -> grants alternate 0,1,0,1, one response per cycle, tags in order.
- Flush and reserved rm:
  - rm=101 -> resp_illegal_o=1, data 0.
  - With resp_ready_i=0 for 3 cycles and two ops in flight, then flush_i=1 -> resp_valid_o=0 the next cycle, no stale responses, rr_ptr unchanged.
